// File: rtl/reorder_buffer_commit_pkg.sv
// Shared types and constants for the reorder buffer commit slice.
package rob_pkg;

  localparam int unsigned ROB_DEPTH       = 32;
  localparam int unsigned ROB_IDX_WIDTH   = $clog2(ROB_DEPTH);
  localparam int unsigned ARCH_ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned COMMIT_WIDTH    = 3;
  localparam int unsigned COUNT_WIDTH     = ROB_IDX_WIDTH + 1;

  typedef logic [ROB_IDX_WIDTH-1:0] rob_idx_t;
  typedef logic [COUNT_WIDTH-1:0]   rob_cnt_t;

  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic [ARCH_ADDR_WIDTH-1:0] rd_arch;
    logic                       rd_we;
    logic                       load_store;
    logic [DATA_WIDTH-1:0]      data;
  } rob_entry_t;

  // Ring-buffer index arithmetic; wraps naturally at ROB_DEPTH.
  function automatic rob_idx_t rob_idx_add(rob_idx_t base, int unsigned off);
    return base + rob_idx_t'(off);
  endfunction

  // Thermometer of free slots: lane k may allocate if more than k slots are free.
  function automatic logic [COMMIT_WIDTH-1:0] ready_mask(rob_cnt_t count);
    int unsigned                free_slots;
    logic [COMMIT_WIDTH-1:0]    mask;
    free_slots = ROB_DEPTH - 32'(count);
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      mask[k] = (free_slots > k);
    end
    return mask;
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_if.sv
// Allocate / CDB / commit bundle between the pipeline and the reorder buffer.
interface reorder_buffer_commit_if
  import rob_pkg::*;
();

  // allocation
  logic [COMMIT_WIDTH-1:0]    alloc_valid;
  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_0;
  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_1;
  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_2;
  logic [COMMIT_WIDTH-1:0]    alloc_rd_we;
  logic [COMMIT_WIDTH-1:0]    alloc_load_store;
  logic [COMMIT_WIDTH-1:0]    alloc_ready;
  rob_idx_t                   alloc_rob_idx_0;
  rob_idx_t                   alloc_rob_idx_1;
  rob_idx_t                   alloc_rob_idx_2;

  // completion broadcast
  logic [COMMIT_WIDTH-1:0]    cdb_valid;
  rob_idx_t                   cdb_rob_idx_0;
  rob_idx_t                   cdb_rob_idx_1;
  rob_idx_t                   cdb_rob_idx_2;
  logic [DATA_WIDTH-1:0]      cdb_data_0;
  logic [DATA_WIDTH-1:0]      cdb_data_1;
  logic [DATA_WIDTH-1:0]      cdb_data_2;

  // retirement
  logic [COMMIT_WIDTH-1:0]    commit_valid;
  logic [ARCH_ADDR_WIDTH-1:0] commit_addr_0;
  logic [ARCH_ADDR_WIDTH-1:0] commit_addr_1;
  logic [ARCH_ADDR_WIDTH-1:0] commit_addr_2;
  rob_idx_t                   commit_rob_idx_0;
  rob_idx_t                   commit_rob_idx_1;
  rob_idx_t                   commit_rob_idx_2;
  logic [DATA_WIDTH-1:0]      commit_data_0;
  logic [DATA_WIDTH-1:0]      commit_data_1;
  logic [DATA_WIDTH-1:0]      commit_data_2;
  logic                       lsq_commit;
  rob_cnt_t                   rob_count;

  modport master (
    output alloc_valid, alloc_rd_arch_0, alloc_rd_arch_1, alloc_rd_arch_2,
           alloc_rd_we, alloc_load_store,
           cdb_valid, cdb_rob_idx_0, cdb_rob_idx_1, cdb_rob_idx_2,
           cdb_data_0, cdb_data_1, cdb_data_2,
    input  alloc_ready, alloc_rob_idx_0, alloc_rob_idx_1, alloc_rob_idx_2,
           commit_valid, commit_addr_0, commit_addr_1, commit_addr_2,
           commit_rob_idx_0, commit_rob_idx_1, commit_rob_idx_2,
           commit_data_0, commit_data_1, commit_data_2,
           lsq_commit, rob_count
  );

  modport slave (
    input  alloc_valid, alloc_rd_arch_0, alloc_rd_arch_1, alloc_rd_arch_2,
           alloc_rd_we, alloc_load_store,
           cdb_valid, cdb_rob_idx_0, cdb_rob_idx_1, cdb_rob_idx_2,
           cdb_data_0, cdb_data_1, cdb_data_2,
    output alloc_ready, alloc_rob_idx_0, alloc_rob_idx_1, alloc_rob_idx_2,
           commit_valid, commit_addr_0, commit_addr_1, commit_addr_2,
           commit_rob_idx_0, commit_rob_idx_1, commit_rob_idx_2,
           commit_data_0, commit_data_1, commit_data_2,
           lsq_commit, rob_count
  );

endinterface

// File: rtl/reorder_buffer_commit_select.sv
// Head-window retirement picker: in-order prefix of done entries, one load/store max.
module rob_commit_select
  import rob_pkg::*;
(
  input  rob_entry_t              win_i [COMMIT_WIDTH],
  output logic [COMMIT_WIDTH-1:0] commit_valid_o,
  output logic                    lsq_commit_o,
  output logic [1:0]              retire_count_o
);

  logic chain;
  logic ls_taken;

  // Walk the window from the head; the first blocked lane ends the group.
  always_comb begin
    commit_valid_o = '0;
    retire_count_o = '0;
    chain          = 1'b1;
    ls_taken       = 1'b0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (chain && win_i[k].valid && win_i[k].done &&
          !(ls_taken && win_i[k].load_store)) begin
        commit_valid_o[k] = 1'b1;
        retire_count_o    = retire_count_o + 2'd1;
        ls_taken          = ls_taken | win_i[k].load_store;
      end else begin
        chain = 1'b0;
      end
    end
    lsq_commit_o = ls_taken;
  end

endmodule

// File: rtl/reorder_buffer_commit.sv
// In-order reorder buffer: 3-wide allocate, 3-port CDB completion, 3-wide retire.
module reorder_buffer_commit
  import rob_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  input logic                    flush,
  reorder_buffer_commit_if.slave rob_if
);

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];
  rob_idx_t   head_q, head_d;
  rob_idx_t   tail_q, tail_d;
  rob_cnt_t   count_q, count_d;

  logic [COMMIT_WIDTH-1:0]    alloc_ready;
  logic [COMMIT_WIDTH-1:0]    accept;
  logic [1:0]                 n_acc;
  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd  [COMMIT_WIDTH];
  rob_idx_t                   cdb_idx   [COMMIT_WIDTH];
  logic [DATA_WIDTH-1:0]      cdb_data  [COMMIT_WIDTH];
  rob_entry_t                 win       [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0]    sel_valid;
  logic                       sel_lsq;
  logic [1:0]                 retire_cnt;

  assign alloc_rd[0] = rob_if.alloc_rd_arch_0;
  assign alloc_rd[1] = rob_if.alloc_rd_arch_1;
  assign alloc_rd[2] = rob_if.alloc_rd_arch_2;
  assign cdb_idx[0]  = rob_if.cdb_rob_idx_0;
  assign cdb_idx[1]  = rob_if.cdb_rob_idx_1;
  assign cdb_idx[2]  = rob_if.cdb_rob_idx_2;
  assign cdb_data[0] = rob_if.cdb_data_0;
  assign cdb_data[1] = rob_if.cdb_data_1;
  assign cdb_data[2] = rob_if.cdb_data_2;

  // Free-slot thermometer comes from the registered count only.
  assign alloc_ready = ready_mask(count_q);
  assign accept      = rob_if.alloc_valid & alloc_ready;
  assign n_acc       = 2'($countones(accept));

  // Gather the three entries starting at head for the picker.
  always_comb begin
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      win[k] = rob_q[rob_idx_add(head_q, k)];
    end
  end

  rob_commit_select u_select (
    .win_i          (win),
    .commit_valid_o (sel_valid),
    .lsq_commit_o   (sel_lsq),
    .retire_count_o (retire_cnt)
  );

  // Next-state: retire clears, then CDB marks done, then allocation writes.
  // Allocated slots are always free at cycle start, so they never overlap retiring ones.
  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rob_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (sel_valid[k]) begin
          rob_d[rob_idx_add(head_q, k)] = '0;
        end
      end
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (rob_if.cdb_valid[k] && rob_q[cdb_idx[k]].valid) begin
          rob_d[cdb_idx[k]].done = 1'b1;
          rob_d[cdb_idx[k]].data = cdb_data[k];
        end
      end
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (accept[k]) begin
          rob_d[rob_idx_add(tail_q, k)] = '{valid:      1'b1,
                                            done:       1'b0,
                                            rd_arch:    alloc_rd[k],
                                            rd_we:      rob_if.alloc_rd_we[k],
                                            load_store: rob_if.alloc_load_store[k],
                                            data:       '0};
        end
      end
      head_d  = head_q + rob_idx_t'(retire_cnt);
      tail_d  = tail_q + rob_idx_t'(n_acc);
      count_d = count_q + rob_cnt_t'(n_acc) - rob_cnt_t'(retire_cnt);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rob_if.alloc_ready     = alloc_ready;
  assign rob_if.alloc_rob_idx_0 = rob_idx_add(tail_q, 0);
  assign rob_if.alloc_rob_idx_1 = rob_idx_add(tail_q, 1);
  assign rob_if.alloc_rob_idx_2 = rob_idx_add(tail_q, 2);

  assign rob_if.commit_valid     = (flush || !reset) ? '0 : sel_valid;
  assign rob_if.lsq_commit       = (flush || !reset) ? 1'b0 : sel_lsq;
  assign rob_if.commit_addr_0    = win[0].rd_we ? win[0].rd_arch : '0;
  assign rob_if.commit_addr_1    = win[1].rd_we ? win[1].rd_arch : '0;
  assign rob_if.commit_addr_2    = win[2].rd_we ? win[2].rd_arch : '0;
  assign rob_if.commit_rob_idx_0 = rob_idx_add(head_q, 0);
  assign rob_if.commit_rob_idx_1 = rob_idx_add(head_q, 1);
  assign rob_if.commit_rob_idx_2 = rob_idx_add(head_q, 2);
  assign rob_if.commit_data_0    = win[0].data;
  assign rob_if.commit_data_1    = win[1].data;
  assign rob_if.commit_data_2    = win[2].data;
  assign rob_if.rob_count        = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= rob_cnt_t'(ROB_DEPTH));

  a_no_overrun: assert property (@(posedge clk) disable iff (!reset)
    rob_cnt_t'(retire_cnt) <= count_q);

  a_alloc_prefix: assert property (@(posedge clk) disable iff (!reset || flush)
    rob_if.alloc_valid inside {3'b000, 3'b001, 3'b011, 3'b111});

endmodule

// File: doc/reorder_buffer_commit.md
Name: reorder_buffer_commit

Overview:
In-order retirement buffer for the 3-way Tomasulo core. It allocates ROB slots to renamed instructions in program order and records completions broadcast on the CDB. It retires up to 3 completed instructions per cycle from the head. Its commit outputs drive the rename stage's commit interface: `commit_addr_*`, `commit_rob_idx_*`, `commit_valid`, `lsq_commit`.

Parameters:
ROB_DEPTH, 32, number of entries (power of two)
ROB_IDX_WIDTH, $clog2(ROB_DEPTH), ROB index width (5)
ARCH_ADDR_WIDTH, 5, architectural register address width
DATA_WIDTH, 32, result data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
flush  in  1  synchronous pipeline flush
alloc_valid  in  3  per-lane allocate request; legal patterns 000/001/011/111 only
alloc_rd_arch_0/1/2  in  ARCH_ADDR_WIDTH  destination architectural register
alloc_rd_we  in  3  per-lane destination write enable
alloc_load_store  in  3  per-lane load/store flag
alloc_ready  out  3  thermometer of free slots: 111 / 011 / 001 / 000
alloc_rob_idx_0/1/2  out  ROB_IDX_WIDTH  slot assigned per lane (tail, tail+1, tail+2)
cdb_valid  in  3  completion broadcast valid
cdb_rob_idx_0/1/2  in  ROB_IDX_WIDTH  completing slot
cdb_data_0/1/2  in  DATA_WIDTH  result
commit_valid  out  3  lane k retires this cycle (prefix pattern)
commit_addr_0/1/2  out  ARCH_ADDR_WIDTH  rd_arch if rd_we else 0
commit_rob_idx_0/1/2  out  ROB_IDX_WIDTH  retiring slot index
commit_data_0/1/2  out  DATA_WIDTH  retiring result
lsq_commit  out  1  a load/store retires this cycle
rob_count  out  ROB_IDX_WIDTH+1  occupied entries (0..32)

Behaviour:
- State: entry array {valid, done, rd_arch, rd_we, load_store, data}; `head`/`tail` pointers (ROB_IDX_WIDTH bits, natural wrap); 6-bit `count`.
- Reset (reset==0 at posedge):
  - All entries invalid; head=tail=count=0.
  - Outputs: commit_valid=000, lsq_commit=0, alloc_ready=111, rob_count=0, alloc_rob_idx_k = k.
  - Takes priority over flush, alloc and CDB.
- Flush (reset==1, flush==1):
  - Same clearing as reset.
  - commit_valid and lsq_commit are forced 0 combinationally in the flush cycle.
  - Alloc and CDB are ignored in that cycle.
- alloc_ready is computed from count at cycle start: free = 32-count. Same-cycle commits do not raise it.
- Allocation:
  - Lane k is accepted iff alloc_valid[k] && alloc_ready[k].
  - Accepted lanes write entries at tail+k with valid=1, done=0.
  - tail advances by the number accepted.
  - alloc_rob_idx_k is combinational, equal to tail+k mod 32, whether or not the lane is accepted.
  - Non-prefix alloc_valid is illegal and is flagged by an assertion.
- CDB:
  - cdb_valid[k] on a valid entry sets done=1 and stores data at the posedge.
  - CDB to an invalid entry is ignored.
  - CDB to the slot being allocated in the same cycle is illegal.
  - Completion at edge N makes the entry committable in cycle N+1. Commit outputs are combinational from registered state.
- Commit selection, lane k = entry head+k:
  - Lane k retires iff entry valid && done && lane k-1 retired.
  - At most one load/store retires per cycle. A second load/store in the group stops the group at that lane; it retires next cycle.
  - lsq_commit=1 iff a retiring lane has load_store=1.
  - Entries with rd_we=0 still retire with commit_valid=1 and commit_addr=0, so the free list regains every slot.
- Pointer and count update:
  - Retired entries are cleared and head advances by the retire count.
  - count_next = count + accepted - retired. Simultaneous alloc and commit is legal, including at count=32 with retire=3, alloc=0.
- Assertions: count never exceeds ROB_DEPTH; never retire past tail.

Decomposition:
- Package rob_pkg: rob_entry_t struct, ROB_DEPTH, ROB_IDX_WIDTH, COMMIT_WIDTH=3.
- One natural sub-module, rob_commit_select: combinational head-window picker. Inputs: 3 entries starting at head. Outputs: commit_valid, lsq_commit, retire_count.

Test Plan:
1. Reset held 2 cycles -> commit_valid=000, lsq_commit=0, alloc_ready=111, rob_count=0, alloc_rob_idx=0/1/2.
2. Alloc 111 with (x5 we), (x6 we), (x0 we=0); CDB idx2, then idx0, then idx1 in successive cycles -> no commit until the cycle after idx1 done. Then commit_valid=111, addr=5/6/0, rob_idx=0/1/2, rob_count 3->0.
3. Allocate until count=30 -> alloc_ready=011. At count=32 -> alloc_ready=000 and alloc_valid=111 is ignored (tail unchanged). Retire 3 at full -> next cycle alloc_ready=111.
4. Head holds two done load/stores plus one done ALU op -> cycle 1: commit_valid=001, lsq_commit=1. Cycle 2: commit_valid=011, lsq_commit=1.
5. Wrap: head=tail=30, alloc 111 -> idx 30/31/0. All three done -> commit rob_idx 30/31/0, head=1.
6. count=10, flush asserted together with alloc_valid=111 and a committable head -> commit_valid=000 that cycle, next cycle rob_count=0, head=tail=0.
